// File: rtl/vscale_md_issue.sv
// vscale_md_issue: issue/writeback controller for the mul/div unit.
// One op in flight; result held until writeback accepts it.
module vscale_md_issue #(
    parameter int OP_WIDTH = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                issue_valid,
    output logic                issue_ready,
    input  logic [OP_WIDTH-1:0] issue_op,
    input  logic                issue_in_1_signed,
    input  logic                issue_in_2_signed,
    input  logic                issue_out_sel,
    input  logic [2:0]          issue_rm,
    input  logic [31:0]         issue_in_1,
    input  logic [31:0]         issue_in_2,
    input  logic [4:0]          issue_rd,
    input  logic                issue_fp,
    input  logic                kill,
    output logic                md_req_valid,
    input  logic                md_req_ready,
    output logic [OP_WIDTH-1:0] md_req_op,
    output logic [2:0]          md_req_rm,
    output logic                md_req_in_1_signed,
    output logic                md_req_in_2_signed,
    output logic                md_req_out_sel,
    output logic [31:0]         md_req_in_1,
    output logic [31:0]         md_req_in_2,
    input  logic                md_resp_valid,
    input  logic [31:0]         md_resp_result,
    output logic                wb_valid,
    input  logic                wb_ready,
    output logic [4:0]          wb_rd,
    output logic                wb_fp,
    output logic [31:0]         wb_data,
    input  logic [4:0]          chk_rs1,
    input  logic [4:0]          chk_rs2,
    input  logic                chk_fp,
    output logic                hazard,
    output logic                busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DRAIN
    } state_t;

    state_t state, state_nx;
    logic   accept;
    logic   capture;
    logic   [4:0] rd_q;
    logic   fp_q;
    logic   pending;

    always_comb begin
        state_nx    = state;
        capture     = 1'b0;
        issue_ready = (state == S_IDLE) || ((state == S_HOLD) && wb_ready);
        accept      = issue_valid && issue_ready && !kill;
        unique case (state)
            S_IDLE: begin
                if (accept) state_nx = S_REQ;
            end
            S_REQ: begin
                // once the unit has taken the request, a kill must wait it out
                if (kill && md_req_ready) state_nx = S_DRAIN;
                else if (kill)            state_nx = S_IDLE;
                else if (md_req_ready)    state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (kill && md_resp_valid) state_nx = S_IDLE;
                else if (kill)             state_nx = S_DRAIN;
                else if (md_resp_valid) begin
                    state_nx = S_HOLD;
                    capture  = 1'b1;
                end
            end
            S_HOLD: begin
                if (kill)          state_nx = S_IDLE;
                else if (wb_ready) state_nx = accept ? S_REQ : S_IDLE;
            end
            S_DRAIN: begin
                if (md_resp_valid) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state              <= S_IDLE;
            md_req_op          <= '0;
            md_req_rm          <= '0;
            md_req_in_1_signed <= 1'b0;
            md_req_in_2_signed <= 1'b0;
            md_req_out_sel     <= 1'b0;
            md_req_in_1        <= '0;
            md_req_in_2        <= '0;
            rd_q               <= '0;
            fp_q               <= 1'b0;
            wb_data            <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                md_req_op          <= issue_op;
                md_req_rm          <= issue_rm;
                md_req_in_1_signed <= issue_in_1_signed;
                md_req_in_2_signed <= issue_in_2_signed;
                md_req_out_sel     <= issue_out_sel;
                md_req_in_1        <= issue_in_1;
                md_req_in_2        <= issue_in_2;
                rd_q               <= issue_rd;
                fp_q               <= issue_fp;
            end
            if (capture) wb_data <= md_resp_result;
        end
    end

    assign md_req_valid = (state == S_REQ);
    assign wb_valid     = (state == S_HOLD);
    assign busy         = (state != S_IDLE);
    assign wb_rd        = rd_q;
    assign wb_fp        = fp_q;

    // integer x0 is hardwired, so it never carries a dependency
    assign pending = (state == S_REQ) || (state == S_WAIT) || (state == S_HOLD);
    assign hazard  = pending && (chk_fp == fp_q)
                   && ((chk_rs1 == rd_q) || (chk_rs2 == rd_q))
                   && (fp_q || (rd_q != 5'd0));

endmodule

// File: doc/vscale_md_issue.md
# vscale_md_issue

Issue/writeback controller between the vscale pipeline and the `vscale_mul_div` unit. Captures one multiply/divide/FP-move request together with its destination register and presents it to the unit with a valid/ready handshake. Catches the single-cycle `resp_valid` pulse and holds the result until the writeback port accepts it. Tracks the pending destination for hazard detection and discards results of killed instructions.

## Interface
- `OP_WIDTH`, default `MDF_OP_WIDTH`: width of the op field; encodings come from `vscale_md_constants.vh`.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `issue_valid` in 1: pipeline offers an op.
- `issue_ready` out 1: op accepted when `issue_valid & issue_ready & ~kill`.
- `issue_op` in OP_WIDTH: MUL/DIV/NOP/SGN.
- `issue_in_1_signed`, `issue_in_2_signed`, `issue_out_sel` in 1 each: forwarded unchanged.
- `issue_rm` in 3: forwarded unchanged.
- `issue_in_1`, `issue_in_2` in 32: operands.
- `issue_rd` in 5: destination register.
- `issue_fp` in 1: destination is the FP register file.
- `kill` in 1: squash the pending op, whatever its state.
- `md_req_valid` out 1, `md_req_ready` in 1: request handshake to the unit.
- `md_req_op`, `md_req_rm`, `md_req_in_1_signed`, `md_req_in_2_signed`, `md_req_out_sel`, `md_req_in_1`, `md_req_in_2` out: registered copies of the issue fields.
- `md_resp_valid` in 1, `md_resp_result` in 32: one-cycle response pulse from the unit.
- `wb_valid` out 1, `wb_ready` in 1: writeback handshake.
- `wb_rd` out 5, `wb_fp` out 1, `wb_data` out 32: writeback payload.
- `chk_rs1`, `chk_rs2` in 5 each, `chk_fp` in 1: source registers of the decoding instruction.
- `hazard` out 1: combinational RAW hazard against the pending destination.
- `busy` out 1: state is not IDLE.

## Operation
- States:
  - IDLE
  - REQ: request presented to the unit.
  - WAIT: request accepted, waiting for the response.
  - HOLD: result captured, awaiting writeback.
  - DRAIN: killed while the unit is running; waiting to discard the response.
- `issue_ready` = IDLE, or HOLD with `wb_ready` in the same cycle (back-to-back issue).
- IDLE or HOLD+`wb_ready`, accepted issue: register all issue fields, `rd`, `fp`; go to REQ.
- REQ: `md_req_valid`=1.
  - `md_req_ready`=1 → WAIT.
  - `kill` → IDLE; no request is sent and `md_req_valid` drops the next cycle.
  - When `kill` and `md_req_ready` are both high, the request is sent and the state goes to DRAIN.
- WAIT:
  - `md_resp_valid` → capture `md_resp_result` into `wb_data`, go to HOLD.
  - `kill` → DRAIN.
  - `kill` and `md_resp_valid` together → IDLE, result discarded.
- DRAIN: `md_resp_valid` → IDLE, result discarded. `kill` is ignored. `issue_ready`=0.
- HOLD: `wb_valid`=1 and the payload is stable.
  - `wb_ready` → IDLE, or REQ if a new issue is accepted in the same cycle.
  - `kill` without `wb_ready` → IDLE with no write.
  - `kill` has priority over `wb_ready`.
- A `md_resp_valid` in IDLE, REQ or HOLD is a protocol error and is ignored.
- `hazard` = (state in REQ/WAIT/HOLD) & (`chk_fp`==fp) & (`chk_rs1`==rd | `chk_rs2`==rd) & (fp | rd!=0). It is 0 in DRAIN and IDLE.
- Payload widths are passed through unchanged; no arithmetic is done in this block.

## Timing
- Reset (asynchronous assert, synchronous-safe release) forces:
  - state IDLE
  - `md_req_valid`=0, `wb_valid`=0, `busy`=0, `hazard`=0
  - `wb_data`=0, `wb_rd`=0, `wb_fp`=0
  - all `md_req_*` fields 0
- Reset mid-operation abandons the op. A response arriving after reset release is ignored.
- Issue accepted at cycle 0 → `md_req_valid` high at cycle 1. `md_req_*` fields are stable while `md_req_valid` is high.
- `md_resp_valid` at cycle N → `wb_valid` and `wb_data` at cycle N+1.
- For NOP/SGN with `md_req_ready` at cycle 1: response at cycle 2, writeback at cycle 3.
- All outputs except `issue_ready` and `hazard` are registered.

## Test plan
- MUL: `in_1`=7, `in_2`=-3, signed, `out_sel`=LO, `rd`=5; unit responds 0xFFFFFFEB 5 cycles after the request → `wb_valid` one cycle later with `wb_data`=0xFFFFFFEB, `wb_rd`=5, `wb_fp`=0. `hazard`=1 for `chk_rs1`=5 throughout.
- `md_req_ready` held low for 3 cycles → `md_req_valid` and all fields stay constant; WAIT is entered only on the ready cycle.
- `kill` in WAIT, then `md_resp_valid` 4 cycles later → no `wb_valid`. `issue_ready`=0 until the cycle after the response, then 1.
- HOLD with `wb_ready`=0 for 5 cycles, then `wb_ready`=1 together with a new `issue_valid` → exactly one writeback, new request at the next cycle, `busy` never drops.
- `kill` and `md_resp_valid` in the same cycle → return to IDLE with no writeback. `kill` and `wb_ready` in the same cycle in HOLD → no write.
- Reset asserted in WAIT → all outputs are at their reset values immediately, with no clock edge needed. A stray `md_resp_valid` after release produces no `wb_valid`. `rd`=0 with `fp`=0 never raises `hazard`.
